// File: rtl/mem_access_pkg.sv
// Shared constants and FSM encoding for the memory-access stage.
// Widths match the execute stage so its result bus connects directly.
package mem_access_pkg;

    localparam int DMEM_ADDR_WIDTH = 12;
    localparam int IALU_WORD_WIDTH = 16;
    localparam int REG_IDX_WIDTH   = 4;
    localparam int PC_WIDTH        = 12;
    localparam int PMEM_WORD_WIDTH = 16;
    localparam int DMEM_TIMEOUT    = 15;
    localparam int WAIT_CNT_WIDTH  = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } req_state_t;

endpackage

// File: rtl/mem_access_if.sv
// DMEM req/ack port: the stage is master, the data memory is slave.
// req, we, addr and wr_word stay stable until ack or abort.
interface mem_access_if #(
    parameter int ADDR_W = 12,
    parameter int WORD_W = 16
);
    logic              out_dmem_req;
    logic              out_dmem_we;
    logic [ADDR_W-1:0] out_dmem_addr;
    logic [WORD_W-1:0] out_dmem_wr_word;
    logic              in_dmem_ack;
    logic [WORD_W-1:0] in_dmem_rd_word;

    modport master (
        output out_dmem_req, out_dmem_we, out_dmem_addr, out_dmem_wr_word,
        input  in_dmem_ack, in_dmem_rd_word
    );

    modport slave (
        input  out_dmem_req, out_dmem_we, out_dmem_addr, out_dmem_wr_word,
        output in_dmem_ack, in_dmem_rd_word
    );
endinterface

// File: rtl/mem_access_dmem_req_ctrl.sv
// DMEM request sequencer: issues req, counts wait cycles, aborts on timeout.
// Latency: zero-wait completion when ack arrives in the issue cycle.
// Backpressure: stall is high while req is pending without ack and not timed out.
module mem_access_dmem_req_ctrl #(
    parameter int DMEM_TIMEOUT = mem_access_pkg::DMEM_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    input  logic access,
    input  logic ack,
    output logic req,
    output logic stall,
    output logic complete,
    output logic abort,
    output logic err
);
    import mem_access_pkg::*;

    localparam logic [WAIT_CNT_WIDTH-1:0] TIMEOUT_CNT = WAIT_CNT_WIDTH'(DMEM_TIMEOUT);

    req_state_t                state;
    req_state_t                state_nxt;
    logic [WAIT_CNT_WIDTH-1:0] cnt;
    logic [WAIT_CNT_WIDTH-1:0] cnt_nxt;
    logic                      err_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            err   <= err_nxt;
        end
    end

    // Reset gates req combinationally so an in-flight access is dropped at once.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        err_nxt   = err;
        req       = 1'b0;
        stall     = 1'b0;
        complete  = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access && !reset) begin
                    req = 1'b1;
                    if (ack) begin
                        complete = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = ST_WAIT;
                        cnt_nxt   = {{(WAIT_CNT_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_WAIT: begin
                if (!reset) begin
                    req = 1'b1;
                    if (ack) begin
                        complete  = 1'b1;
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt == TIMEOUT_CNT) begin
                        abort     = 1'b1;
                        err_nxt   = 1'b1;
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end else begin
                        stall   = 1'b1;
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: registers execute results, performs DMEM load/store.
// Latency: one cycle execute->writeback plus DMEM wait cycles.
// Backpressure: out_stall holds upstream while an access waits for ack.
module mem_access #(
    parameter int DMEM_ADDR_WIDTH = mem_access_pkg::DMEM_ADDR_WIDTH,
    parameter int DMEM_WORD_WIDTH = mem_access_pkg::IALU_WORD_WIDTH,
    parameter int IALU_WORD_WIDTH = mem_access_pkg::IALU_WORD_WIDTH,
    parameter int PC_WIDTH        = mem_access_pkg::PC_WIDTH,
    parameter int PMEM_WORD_WIDTH = mem_access_pkg::PMEM_WORD_WIDTH,
    parameter int REG_IDX_WIDTH   = mem_access_pkg::REG_IDX_WIDTH,
    parameter int DMEM_TIMEOUT    = mem_access_pkg::DMEM_TIMEOUT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_act_load_dmem,
    input  logic                       in_act_store_dmem,
    input  logic                       in_act_write_res_to_reg,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_rd_addr,
    input  logic [DMEM_ADDR_WIDTH-1:0] in_dmem_wr_addr,
    input  logic [DMEM_WORD_WIDTH-1:0] in_dmem_wr_word,
    input  logic [PMEM_WORD_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]        in_pc,
    input  logic [IALU_WORD_WIDTH-1:0] in_res,
    input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    mem_access_if.master               dmem,
    output logic                       out_stall,
    output logic                       out_act_write_res_to_reg,
    output logic [IALU_WORD_WIDTH-1:0] out_res,
    output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
    output logic [PMEM_WORD_WIDTH-1:0] out_instr,
    output logic [PC_WIDTH-1:0]        out_pc,
    output logic                       out_dmem_err
);
    import mem_access_pkg::*;

    typedef struct packed {
        logic                       load;
        logic                       store;
        logic                       write_res;
        logic [DMEM_ADDR_WIDTH-1:0] rd_addr;
        logic [DMEM_ADDR_WIDTH-1:0] wr_addr;
        logic [DMEM_WORD_WIDTH-1:0] wr_word;
        logic [PMEM_WORD_WIDTH-1:0] instr;
        logic [PC_WIDTH-1:0]        pc;
        logic [IALU_WORD_WIDTH-1:0] res;
        logic [REG_IDX_WIDTH-1:0]   reg_idx;
    } stage_t;

    stage_t stg;
    stage_t stg_in;

    logic access;
    logic req;
    logic stall;
    logic complete;
    logic abort;
    logic wb_vld;
    logic load_done;

    assign stg_in.load      = in_act_load_dmem;
    assign stg_in.store     = in_act_store_dmem;
    assign stg_in.write_res = in_act_write_res_to_reg;
    assign stg_in.rd_addr   = in_dmem_rd_addr;
    assign stg_in.wr_addr   = in_dmem_wr_addr;
    assign stg_in.wr_word   = in_dmem_wr_word;
    assign stg_in.instr     = in_instr;
    assign stg_in.pc        = in_pc;
    assign stg_in.res       = in_res;
    assign stg_in.reg_idx   = in_res_reg_idx;

    always_ff @(posedge clock) begin
        if (reset) begin
            stg <= '0;
        end else if (!stall) begin
            stg <= stg_in;
        end
    end

    assign access = stg.load | stg.store;

    mem_access_dmem_req_ctrl #(
        .DMEM_TIMEOUT (DMEM_TIMEOUT)
    ) u_req_ctrl (
        .clock    (clock),
        .reset    (reset),
        .access   (access),
        .ack      (dmem.in_dmem_ack),
        .req      (req),
        .stall    (stall),
        .complete (complete),
        .abort    (abort),
        .err      (out_dmem_err)
    );

    // Store takes priority when execute flags both load and store.
    assign dmem.out_dmem_req     = req;
    assign dmem.out_dmem_we      = stg.store;
    assign dmem.out_dmem_addr    = stg.store ? stg.wr_addr : stg.rd_addr;
    assign dmem.out_dmem_wr_word = stg.wr_word;

    assign out_stall = stall;
    assign wb_vld    = !reset && !stall && !abort;
    assign load_done = complete && stg.load && !stg.store;

    always_comb begin
        out_act_write_res_to_reg = 1'b0;
        out_res                  = '0;
        out_res_reg_idx          = '0;
        out_instr                = '0;
        out_pc                   = '0;
        if (wb_vld) begin
            out_act_write_res_to_reg = stg.write_res;
            out_res                  = load_done ? IALU_WORD_WIDTH'(dmem.in_dmem_rd_word) : stg.res;
            out_res_reg_idx          = stg.reg_idx;
            out_instr                = stg.instr;
            out_pc                   = stg.pc;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios then random traffic against a transaction model.
module tb_mem_access;

    localparam int TO = 4;

    typedef struct packed {
        logic        ld;
        logic        st;
        logic        wr;
        logic [11:0] rd_addr;
        logic [11:0] wr_addr;
        logic [15:0] wr_word;
        logic [15:0] instr;
        logic [11:0] pc;
        logic [15:0] res;
        logic [3:0]  idx;
    } stim_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_act_load_dmem, in_act_store_dmem, in_act_write_res_to_reg;
    logic [11:0] in_dmem_rd_addr, in_dmem_wr_addr;
    logic [15:0] in_dmem_wr_word, in_instr, in_res;
    logic [11:0] in_pc;
    logic [3:0]  in_res_reg_idx;
    logic        out_stall, out_act_write_res_to_reg, out_dmem_err;
    logic [15:0] out_res, out_instr;
    logic [3:0]  out_res_reg_idx;
    logic [11:0] out_pc;

    mem_access_if #(.ADDR_W(12), .WORD_W(16)) dmem ();

    mem_access #(
        .DMEM_ADDR_WIDTH (12), .DMEM_WORD_WIDTH (16), .IALU_WORD_WIDTH (16),
        .PC_WIDTH (12), .PMEM_WORD_WIDTH (16), .REG_IDX_WIDTH (4), .DMEM_TIMEOUT (TO)
    ) dut (
        .clock                    (clock),
        .reset                    (reset),
        .in_act_load_dmem         (in_act_load_dmem),
        .in_act_store_dmem        (in_act_store_dmem),
        .in_act_write_res_to_reg  (in_act_write_res_to_reg),
        .in_dmem_rd_addr          (in_dmem_rd_addr),
        .in_dmem_wr_addr          (in_dmem_wr_addr),
        .in_dmem_wr_word          (in_dmem_wr_word),
        .in_instr                 (in_instr),
        .in_pc                    (in_pc),
        .in_res                   (in_res),
        .in_res_reg_idx           (in_res_reg_idx),
        .dmem                     (dmem.master),
        .out_stall                (out_stall),
        .out_act_write_res_to_reg (out_act_write_res_to_reg),
        .out_res                  (out_res),
        .out_res_reg_idx          (out_res_reg_idx),
        .out_instr                (out_instr),
        .out_pc                   (out_pc),
        .out_dmem_err             (out_dmem_err)
    );

    always #5 clock = ~clock;

    // Reference model: the instruction held in the stage, how many request
    // cycles it has already spent, and the sticky error flag.
    stim_t cur;
    int    waited;
    bit    err_m;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic stim_t mk(input bit ld, input bit st, input bit wr,
                                 input logic [11:0] ra, input logic [11:0] wa,
                                 input logic [15:0] wd, input logic [15:0] res,
                                 input logic [3:0] idx);
        stim_t s;
        s.ld = ld; s.st = st; s.wr = wr;
        s.rd_addr = ra; s.wr_addr = wa; s.wr_word = wd;
        s.instr = 16'($urandom); s.pc = 12'($urandom);
        s.res = res; s.idx = idx;
        return s;
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        s = stim_t'({$urandom, $urandom, $urandom, $urandom});
        return s;
    endfunction

    task automatic step(input stim_t s, input logic ack, input logic [15:0] rd, input logic rst);
        bit          req_e, tmo, stl, vld, ld_done;
        logic [15:0] res_e;
        @(negedge clock);
        in_act_load_dmem        = s.ld;
        in_act_store_dmem       = s.st;
        in_act_write_res_to_reg = s.wr;
        in_dmem_rd_addr         = s.rd_addr;
        in_dmem_wr_addr         = s.wr_addr;
        in_dmem_wr_word         = s.wr_word;
        in_instr                = s.instr;
        in_pc                   = s.pc;
        in_res                  = s.res;
        in_res_reg_idx          = s.idx;
        dmem.in_dmem_ack        = ack;
        dmem.in_dmem_rd_word    = rd;
        reset                   = rst;
        #2;
        req_e   = (cur.ld || cur.st) && !rst;
        tmo     = req_e && !ack && (waited == TO);
        stl     = req_e && !ack && !tmo;
        vld     = !rst && !stl && !tmo;
        ld_done = req_e && ack && cur.ld && !cur.st;
        res_e   = !vld ? 16'h0 : (ld_done ? rd : cur.res);

        chk("req",   32'(dmem.out_dmem_req), 32'(req_e));
        chk("stall", 32'(out_stall), 32'(stl));
        chk("err",   32'(out_dmem_err), 32'(err_m));
        chk("wb_we", 32'(out_act_write_res_to_reg), 32'(vld && cur.wr));
        chk("res",   32'(out_res), 32'(res_e));
        chk("idx",   32'(out_res_reg_idx), vld ? 32'(cur.idx) : 32'h0);
        chk("instr", 32'(out_instr), vld ? 32'(cur.instr) : 32'h0);
        chk("pc",    32'(out_pc), vld ? 32'(cur.pc) : 32'h0);
        if (req_e) begin
            chk("we",      32'(dmem.out_dmem_we), 32'(cur.st));
            chk("addr",    32'(dmem.out_dmem_addr), cur.st ? 32'(cur.wr_addr) : 32'(cur.rd_addr));
            chk("wr_word", 32'(dmem.out_dmem_wr_word), 32'(cur.wr_word));
        end

        if (rst) begin
            cur = '0; waited = 0; err_m = 1'b0;
        end else if (stl) begin
            waited++;
        end else begin
            if (tmo) err_m = 1'b1;
            cur    = s;
            waited = 0;
        end
    endtask

    stim_t nop;

    initial begin
        nop = '0;
        reset = 1'b1;
        {in_act_load_dmem, in_act_store_dmem, in_act_write_res_to_reg} = 3'b000;
        in_dmem_rd_addr = '0; in_dmem_wr_addr = '0; in_dmem_wr_word = '0;
        in_instr = '0; in_pc = '0; in_res = '0; in_res_reg_idx = '0;
        dmem.in_dmem_ack = 1'b0; dmem.in_dmem_rd_word = '0;
        repeat (2) @(posedge clock);
        cur = '0; waited = 0; err_m = 1'b0;

        // ALU op, then zero-wait load with a stray ack while nothing is requested
        step(mk(0, 0, 1, 12'h000, 12'h000, 16'h0000, 16'h1234, 4'd3), 1'b0, 16'h0, 1'b0);
        step(mk(1, 0, 1, 12'h040, 12'h000, 16'h0000, 16'h5555, 4'd5), 1'b1, 16'h0, 1'b0);
        // store with three wait cycles
        step(mk(0, 1, 0, 12'h000, 12'h010, 16'h00AA, 16'h7777, 4'd6), 1'b1, 16'hBEEF, 1'b0);
        repeat (3) step(nop, 1'b0, 16'h0, 1'b0);
        // timeout on a load that is never acknowledged
        step(mk(1, 0, 1, 12'h0F0, 12'h000, 16'h0000, 16'h1111, 4'd7), 1'b1, 16'h0, 1'b0);
        repeat (4) step(nop, 1'b0, 16'h0, 1'b0);
        // load+store both set: store wins, result is in_res
        step(mk(1, 1, 1, 12'h0F1, 12'h020, 16'h3C3C, 16'h4242, 4'd8), 1'b0, 16'h0, 1'b0);
        step(mk(1, 0, 1, 12'h080, 12'h000, 16'h0000, 16'h9999, 4'd9), 1'b1, 16'hDEAD, 1'b0);
        // reset in the second wait cycle of a load
        step(nop, 1'b0, 16'h0, 1'b0);
        step(nop, 1'b0, 16'h0, 1'b0);
        step(nop, 1'b0, 16'h0, 1'b1);
        step(nop, 1'b1, 16'h0, 1'b0);

        for (int blk = 0; blk < 6; blk++) begin
            int ack_pct;
            ack_pct = (blk % 3 == 0) ? 90 : (blk % 3 == 1) ? 35 : 12;
            for (int i = 0; i < 400; i++) begin
                step(rnd_stim(), ($urandom_range(0, 99) < ack_pct),
                     16'($urandom), ($urandom_range(0, 149) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Pipeline stage directly downstream of the execute stage.
- Registers execute-stage results and performs the data-memory load or store through a req/ack DMEM port.
- Stalls the pipeline while an access is outstanding.
- Hands result, destination register index and write-enable to the writeback stage.

Parameters:
DMEM_ADDR_WIDTH, 12, data memory address width
DMEM_WORD_WIDTH, 16, data memory word width (equals IALU_WORD_WIDTH)
IALU_WORD_WIDTH, 16, result word width
PC_WIDTH, 12, program counter width
PMEM_WORD_WIDTH, 16, instruction word width
REG_IDX_WIDTH, 4, register index width
DMEM_TIMEOUT, 15, max wait cycles for ack before abort (1..255)

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high
in_act_load_dmem  in  1  execute requests load
in_act_store_dmem  in  1  execute requests store
in_act_write_res_to_reg  in  1  result is written to register file
in_dmem_rd_addr  in  DMEM_ADDR_WIDTH  load address
in_dmem_wr_addr  in  DMEM_ADDR_WIDTH  store address
in_dmem_wr_word  in  DMEM_WORD_WIDTH  store data
in_instr  in  PMEM_WORD_WIDTH  instruction (debug/trace)
in_pc  in  PC_WIDTH  instruction PC
in_res  in  IALU_WORD_WIDTH  ALU result
in_res_reg_idx  in  REG_IDX_WIDTH  destination register
in_dmem_ack  in  1  DMEM completes current request
in_dmem_rd_word  in  DMEM_WORD_WIDTH  read data, valid with ack
out_dmem_req  out  1  access request
out_dmem_we  out  1  1=write, 0=read
out_dmem_addr  out  DMEM_ADDR_WIDTH  access address
out_dmem_wr_word  out  DMEM_WORD_WIDTH  write data
out_stall  out  1  upstream stages must hold
out_act_write_res_to_reg  out  1  writeback enable
out_res  out  IALU_WORD_WIDTH  writeback value
out_res_reg_idx  out  REG_IDX_WIDTH  writeback register
out_instr  out  PMEM_WORD_WIDTH  instruction passed on
out_pc  out  PC_WIDTH  PC passed on
out_dmem_err  out  1  sticky timeout flag

Behaviour:
- Reset: one clock, one synchronous active-high reset. At a rising edge with reset=1, all stage registers, FSM (IDLE), wait counter and err clear to 0.
- Reset gating: out_dmem_req is gated by !reset combinationally. An access in flight when reset asserts is abandoned without writeback.
- Input capture: stage registers load all in_* on every edge where out_stall=0. They hold when out_stall=1.
- Access: access_ff = load_ff | store_ff. If both are set, the store wins and the load is suppressed; the result is res_ff.
- FSM states: IDLE and WAIT.
  - IDLE, access_ff=1: out_dmem_req=1.
    - we=store_ff; addr = store ? wr_addr_ff : rd_addr_ff; wr_word = wr_word_ff.
    - ack same cycle: zero-wait completion, stall=0.
    - No ack: stall=1, go to WAIT, wait counter=1.
  - WAIT: req held with identical addr/we/data; stall=1; counter increments each cycle.
    - On ack: completion, stall=0, next state IDLE.
    - Counter reaches DMEM_TIMEOUT with no ack: abort. req stays 1 that final cycle, stall=0, err set (sticky until reset), instruction retired as a bubble, next state IDLE.
  - ack while req=0: ignored.
- Writeback outputs (combinational from registers):
  - Valid only in a non-stalled cycle. In a stalled or aborted cycle, out_act_write_res_to_reg, out_res, out_res_reg_idx, out_instr and out_pc are all 0.
  - Completed load: out_res = in_dmem_rd_word sampled in the ack cycle.
  - Otherwise: out_res = res_ff.
  - write_res, reg_idx, instr and pc come from their stage registers.
- Latency: one cycle from execute to writeback outputs, plus DMEM wait cycles.
- Back-to-back accesses: a new access issues in the cycle after completion. There is no idle cycle between accesses.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=0, WAIT=1).
  - Width constants shared with the execute stage (DMEM_ADDR_WIDTH, IALU_WORD_WIDTH, REG_IDX_WIDTH, PC_WIDTH).
  - Default DMEM_TIMEOUT.
- Sub-module dmem_req_ctrl: contains the FSM, wait counter, err flag, and the req/stall/abort/complete signals.
- Top module: stage registers and writeback muxing.

Test Plan:
- ALU op, no access: res=0x1234, idx=3, write=1 → next cycle out_res=0x1234, idx=3, write=1, req=0, stall=0.
- Zero-wait load: rd_addr=0x040, ack tied 1, rd_word=0xBEEF, idx=5 → req=1, we=0, addr=0x040, out_res=0xBEEF, write=1, stall never 1.
- Store with 3 wait cycles: wr_addr=0x010, wr_word=0x00AA, ack on 4th req cycle → stall=1 for 3 cycles with req/addr/data stable, then write=0 (store, no reg write) and upstream resumes.
- Timeout: DMEM_TIMEOUT=4, load, ack never → stall for 4 cycles, abort with bubble, err=1 and stays 1 across further traffic until reset.
- Load+store both set: store wr_addr=0x020 issued with we=1, no read, out_res=in_res.
- Reset mid-WAIT: reset in cycle 2 of wait → req=0 that cycle, next cycle IDLE, all outputs 0, err=0.
